// File: rtl/seq_lock_pkg.sv
// Shared state encoding and sizing helpers for the serial combination lock.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    StCollect  = 2'd0,
    StUnlocked = 2'd1,
    StLockout  = 2'd2
  } state_e;

  // Bits needed to hold values 0..n; never returns less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lock_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Expires on the edge where the counter holds 1, leaving it idle at 0.
  assign expired_o = (cnt_q == Width'(1));

endmodule

// File: rtl/seq_lock.sv
// Serial combination lock: fixed-length code windows, reprogrammable code,
// bounded unlock strobe, failed-attempt counting and timed lockout.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int unsigned         CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         UNLOCK_CYCLES  = 8,
  parameter int unsigned         LOCKOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               Reset,
  input  logic                               a,
  input  logic                               a_valid,
  input  logic                               prog,
  input  logic [CODE_LEN-1:0]                new_code,
  output logic                               unlck,
  output logic                               locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam int unsigned BitW  = cnt_width(CODE_LEN - 1);
  localparam int unsigned TmrW  = cnt_width(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES));

  localparam logic [FailW-1:0] MaxTries   = FailW'(MAX_TRIES);
  localparam logic [BitW-1:0]  LastBit    = BitW'(CODE_LEN - 1);
  localparam logic [TmrW-1:0]  UnlockLoad = TmrW'(UNLOCK_CYCLES);
  localparam logic [TmrW-1:0]  LockLoad   = TmrW'(LOCKOUT_CYCLES);

  state_e              state_q, state_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  // Only the newest CODE_LEN-1 bits are ever needed; the incoming bit completes the window.
  logic [CODE_LEN-2:0] shreg_q, shreg_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [FailW-1:0]    fail_q, fail_d;
  logic                unlck_q, locked_q;

  logic                tmr_load;
  logic [TmrW-1:0]     tmr_val;
  logic                tmr_expired;
  logic [CODE_LEN-1:0] window;
  logic [FailW-1:0]    fail_inc;

  lock_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk        (clk),
    .Reset      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign window   = {shreg_q, a};
  assign fail_inc = fail_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    code_d    = code_q;
    fail_d    = fail_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      StCollect: begin
        if (a_valid) begin
          shreg_d = window[CODE_LEN-2:0];
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            if (window == code_q) begin
              state_d  = StUnlocked;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = UnlockLoad;
            end else if (fail_inc == MaxTries) begin
              state_d  = StLockout;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = LockLoad;
            end else begin
              fail_d = fail_inc;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StUnlocked: begin
        if (prog) begin
          code_d = new_code;
        end
        if (tmr_expired) begin
          state_d   = StCollect;
          bit_cnt_d = '0;
        end
      end
      StLockout: begin
        if (tmr_expired) begin
          state_d   = StCollect;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = StCollect;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StCollect;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      code_q    <= DEFAULT_CODE;
      fail_q    <= '0;
      unlck_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      code_q    <= code_d;
      fail_q    <= fail_d;
      unlck_q   <= (state_d == StUnlocked);
      locked_q  <= (state_d == StLockout);
    end
  end

  assign unlck      = unlck_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_seq_lock.sv
// Directed self-checking bench for seq_lock with default parameters.
module tb_seq_lock;

  logic       clk = 1'b0;
  logic       Reset;
  logic       a;
  logic       a_valid;
  logic       prog;
  logic [4:0] new_code;
  logic       unlck;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_lock #(
    .CODE_LEN       (5),
    .DEFAULT_CODE   (5'b01011),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .a          (a),
    .a_valid    (a_valid),
    .prog       (prog),
    .new_code   (new_code),
    .unlck      (unlck),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    a       = b;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
  endtask

  task automatic enter(input logic [4:0] c, input bit gaps);
    for (int i = 4; i >= 0; i--) begin
      send_bit(c[i]);
      if (gaps && i > 0) begin
        step();
        step();
      end
    end
  endtask

  // Called right after the final-bit edge; optionally pulses prog with a bit.
  task automatic expect_unlock(input string tag, input bit do_prog, input logic [4:0] nc);
    for (int i = 0; i < 8; i++) begin
      check({tag, " unlck_high"}, unlck, 1);
      if (do_prog && i == 2) begin
        prog     = 1'b1;
        new_code = nc;
        a        = 1'b1;
        a_valid  = 1'b1;
      end
      step();
      prog    = 1'b0;
      a_valid = 1'b0;
    end
    check({tag, " unlck_fall"}, unlck, 0);
  endtask

  // Called right after the failing final-bit edge; tries a code meanwhile.
  task automatic expect_lockout(input string tag, input logic [4:0] try_code);
    for (int i = 0; i < 16; i++) begin
      check({tag, " locked_high"}, locked_out, 1);
      check({tag, " no_unlck"}, unlck, 0);
      if (i < 5) begin
        a       = try_code[4-i];
        a_valid = 1'b1;
      end
      step();
      a_valid = 1'b0;
    end
    check({tag, " locked_fall"}, locked_out, 0);
    check({tag, " no_unlck_after"}, unlck, 0);
  endtask

  initial begin
    a        = 1'b0;
    a_valid  = 1'b0;
    prog     = 1'b0;
    new_code = 5'b00000;
    Reset    = 1'b1;
    step();
    step();
    Reset = 1'b0;
    check("reset unlck", unlck, 0);
    check("reset locked_out", locked_out, 0);
    check("reset fail_cnt", fail_cnt, 0);

    // Default code with gaps in a_valid.
    enter(5'b01011, 1'b1);
    check("gap fail_cnt", fail_cnt, 0);
    expect_unlock("gap", 1'b0, 5'b00000);

    // Three wrong entries lead to lockout; a correct code during lockout is ignored.
    enter(5'b11111, 1'b0);
    check("fail1 fail_cnt", fail_cnt, 1);
    check("fail1 unlck", unlck, 0);
    enter(5'b11111, 1'b0);
    check("fail2 fail_cnt", fail_cnt, 2);
    check("fail2 locked_out", locked_out, 0);
    enter(5'b11111, 1'b0);
    check("fail3 fail_cnt", fail_cnt, 0);
    expect_lockout("lockout", 5'b01011);

    // First bit after lockout is accepted; then reprogram while unlocked.
    enter(5'b01011, 1'b0);
    expect_unlock("prog", 1'b1, 5'b11100);
    enter(5'b01011, 1'b0);
    check("old_code fail_cnt", fail_cnt, 1);
    check("old_code unlck", unlck, 0);
    enter(5'b11100, 1'b0);
    check("new_code fail_cnt", fail_cnt, 0);
    expect_unlock("new_code", 1'b0, 5'b00000);

    // Reset restores the default code; prog in COLLECT has no effect.
    do_reset();
    prog     = 1'b1;
    new_code = 5'b00000;
    step();
    prog = 1'b0;
    enter(5'b00000, 1'b0);
    check("collect_prog fail_cnt", fail_cnt, 1);
    check("collect_prog unlck", unlck, 0);
    enter(5'b01011, 1'b0);
    check("default_restored fail_cnt", fail_cnt, 0);
    expect_unlock("default_restored", 1'b0, 5'b00000);

    // Reset mid-entry and mid-unlock.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    check("mid_entry unlck", unlck, 0);
    check("mid_entry fail_cnt", fail_cnt, 0);
    enter(5'b01011, 1'b0);
    check("mid_entry reentry unlck", unlck, 1);
    step();
    step();
    do_reset();
    check("mid_unlock unlck", unlck, 0);
    enter(5'b01011, 1'b0);
    expect_unlock("after_reset", 1'b0, 5'b00000);

    // Windows do not slide: 1,0,1,0,1 then 1 ends with 01011 but must not unlock.
    enter(5'b10101, 1'b0);
    check("noslide fail_cnt", fail_cnt, 1);
    send_bit(1'b1);
    check("noslide unlck", unlck, 0);
    check("noslide mid fail_cnt", fail_cnt, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("noslide2 fail_cnt", fail_cnt, 2);

    // Success after two failures clears the count; two more do not lock out.
    enter(5'b01011, 1'b0);
    check("clear fail_cnt", fail_cnt, 0);
    expect_unlock("clear", 1'b0, 5'b00000);
    enter(5'b00110, 1'b0);
    enter(5'b00110, 1'b0);
    check("two_more fail_cnt", fail_cnt, 2);
    check("two_more locked_out", locked_out, 0);

    // Reset mid-lockout.
    enter(5'b00110, 1'b0);
    check("lock_again locked_out", locked_out, 1);
    step();
    do_reset();
    check("mid_lockout locked_out", locked_out, 0);
    check("mid_lockout fail_cnt", fail_cnt, 0);
    enter(5'b01011, 1'b0);
    check("post_lockout_reset unlck", unlck, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_lock.md
# seq_lock

Parametrised serial combination lock: next generation of the single-pattern unlock FSM. Bits arrive serially on `a` qualified by `a_valid`, are collected into a fixed-length window, and are compared against a code register. The code register is reprogrammable and resets to the legacy 0-1-0-1-1 pattern. The block adds a bounded unlock pulse, failed-attempt counting and a timed lockout, and sits between the input debouncer and the actuator driver.

## Interface
- `CODE_LEN`, 5: bits per code entry; legal range 2–32.
- `DEFAULT_CODE`, 5'b01011: code register value after reset. MSB is the first bit entered.
- `MAX_TRIES`, 3: consecutive failed entries that trigger lockout; legal range ≥1.
- `UNLOCK_CYCLES`, 8: cycles `unlck` stays high per success; legal range ≥1.
- `LOCKOUT_CYCLES`, 16: cycles input is ignored after lockout; legal range ≥1.
- `clk`  in  1  clock.
- `Reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `a`  in  1  serial code bit.
- `a_valid`  in  1  qualifies `a`; one bit is accepted per cycle in which this is high.
- `prog`  in  1  load `new_code` into the code register; honoured only in UNLOCKED.
- `new_code`  in  CODE_LEN  replacement code.
- `unlck`  out  1  registered unlock strobe.
- `locked_out`  out  1  registered; high while in LOCKOUT.
- `fail_cnt`  out  $clog2(MAX_TRIES+1)  consecutive failures so far.

## Operation
- States: COLLECT, UNLOCKED, LOCKOUT.
- COLLECT:
  - Each accepted bit shifts into `shreg` (shift left, new bit enters the LSB) and increments `bit_cnt`.
  - On the edge that accepts bit number CODE_LEN, the window `{shreg[CODE_LEN-2:0], a}` is compared with `code_reg`, and `bit_cnt` returns to 0.
  - Windows do not overlap; there is no sliding match.
- Match:
  - Go to UNLOCKED.
  - `fail_cnt` ← 0.
  - Load the timer with UNLOCK_CYCLES.
- Mismatch:
  - `fail_cnt` increments.
  - If the new value equals MAX_TRIES: go to LOCKOUT, `fail_cnt` ← 0, load the timer with LOCKOUT_CYCLES.
  - Otherwise: stay in COLLECT.
- UNLOCKED:
  - `a_valid` is ignored.
  - `prog` loads `new_code` into `code_reg`.
  - When the timer expires, return to COLLECT with `bit_cnt` = 0.
- LOCKOUT:
  - `a_valid` and `prog` are ignored.
  - When the timer expires, return to COLLECT.
- `prog` outside UNLOCKED: no effect.
- Same-cycle `prog` and `a_valid` in UNLOCKED: `prog` is honoured and the bit is dropped.

## Timing
- Reset values:
  - `unlck` = 0, `locked_out` = 0, `fail_cnt` = 0.
  - State = COLLECT, `bit_cnt` = 0, `shreg` = 0.
  - `code_reg` = DEFAULT_CODE, timer = 0.
- `unlck` latency:
  - `unlck` rises in the cycle after the final-bit edge.
  - It stays high for exactly UNLOCK_CYCLES cycles.
  - It falls in the same cycle the state returns to COLLECT.
- `locked_out`:
  - Rises in the cycle after the failing final-bit edge.
  - Stays high for exactly LOCKOUT_CYCLES cycles.
- First bit accepted after either timer expires: the bit presented in the first cycle in which `unlck` or `locked_out` is low.
- A new `code_reg` value applies to the next completed window.
- Timer: down-counter that expires on the edge where it holds 1.
- Reset mid-entry, mid-unlock or mid-lockout:
  - All state returns to reset values on the next edge.
  - `code_reg` reverts to DEFAULT_CODE.
- Gaps in `a_valid` within an entry are legal; there is no inter-bit timeout.

## Structure
- `seq_lock_pkg` holds:
  - the state encoding: COLLECT = 2'd0, UNLOCKED = 2'd1, LOCKOUT = 2'd2;
  - the counter-width helper functions.
- 2'd3 is illegal and recovers to COLLECT on the next edge.
- Sub-module `lock_timer` (load value, load strobe, expired flag) is instantiated once. It serves both UNLOCKED and LOCKOUT, sized to the larger of UNLOCK_CYCLES and LOCKOUT_CYCLES.

## Test plan
- After reset, enter 0,1,0,1,1 with gaps in `a_valid` → `unlck` is high for 8 cycles starting the cycle after the 5th bit; `fail_cnt` = 0.
- Enter 1,1,1,1,1 three times → `fail_cnt` reads 1, then 2; after the third entry `locked_out` is high for 16 cycles and `fail_cnt` = 0. A correct code entered during lockout produces no `unlck`.
- Unlock, then pulse `prog` with `new_code` = 5'b11100 → 01011 fails, and 1,1,1,0,0 unlocks.
- In COLLECT, pulse `prog` with 5'b00000 → no effect; 01011 still unlocks.
- Enter 3 bits, then assert `Reset`, then enter 0,1,0,1,1 → unlock. Separately, a reset after reprogramming restores 01011.
- Two failures, then a success → `fail_cnt` returns to 0. A further two failures do not cause lockout.
